ifarb_multi: RTL and testbench
==============================

# ifarb_multi

Parametrised successor of the global-buffer interface arbiter, sitting between the NUM_CH on-chip global buffers (flag/weight/activation refill, flag/OFM drain) and the single off-chip interface port. Each channel tracks its own occupancy from enable strobes and raises a refill or drain request against a run-time watermark. A burst-granting FSM chooses one requester with class priority and optional round-robin. It then drives a level request for a counted, occupancy-truncated burst, and supports flush and per-channel reset.

## Interface
Parameters:
- NUM_CH, 6, number of buffer channels
- ADDR_W, 5, buffer address width; DEPTH = 2**ADDR_W words
- CFG_W, 4, width of IF_Cfg
- BURST_LEN, 8, maximum beats per grant (1..DEPTH)
- CH_DIR, 6'b110000, per-channel bit: 1 = drain (write to interface), 0 = refill (read)
- CH_CFG, {4'd11,4'd10,4'd2,4'd4,4'd6,4'd8}, packed per-channel IF_Cfg code, channel 0 in LSBs
- CFG_CODE, 4'd0, IF_Cfg code for CFG_Req bursts
- IDLE_CODE, 4'd15, IF_Cfg code when nothing granted

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high global reset
- ChReset  in  NUM_CH  synchronous per-channel clear of occupancy and error
- EnWr  in  NUM_CH  buffer write strobe per channel
- EnRd  in  NUM_CH  buffer read strobe per channel
- Thresh  in  NUM_CH*(ADDR_W+1)  watermark per channel
- Flush  in  NUM_CH  force drain of any non-zero occupancy (drain channels only)
- CFG_Req  in  1  configuration fetch request
- RR_En  in  1  1 = round-robin within class, 0 = fixed lowest index
- IF_Val  in  1  interface valid
- IF_Rdy  in  1  interface ready
- IF_Req  out  1  level request, held for the whole burst
- IF_RdWr  out  1  1 = read (refill/CFG), 0 = write (drain)
- IF_Cfg  out  CFG_W  code of granted source
- Grant  out  NUM_CH  one-hot granted channel (0 for CFG or idle)
- Occ  out  NUM_CH*(ADDR_W+1)  occupancy per channel, 0..DEPTH
- Err  out  NUM_CH  sticky overflow/underflow flag

## Operation
- Occupancy per channel: +1 on EnWr, -1 on EnRd, unchanged if both. EnWr at Occ=DEPTH or EnRd at Occ=0 is ignored and sets Err.
- Channel request:
  - Refill channel: DEPTH-Occ >= Thresh.
  - Drain channel: Occ >= Thresh, or Flush && Occ>0.
  - Thresh=0 on a refill channel requests only when a free word exists.
- Priority: CFG_Req > drain channels > refill channels.
  - Within a class, RR_En=0 selects the lowest index.
  - RR_En=1 selects the first requester after the last index granted in that class, wrapping at NUM_CH-1 to 0.
- FSM states:
  - IDLE: no requester -> stay in IDLE; else latch winner, IF_Cfg, IF_RdWr, beat count -> BURST.
  - BURST: IF_Req=1; a beat occurs when IF_Val && IF_Rdy; at the last beat -> IDLE.
- Beat count latched at grant:
  - CFG: 1.
  - Drain: min(BURST_LEN, Occ).
  - Refill: min(BURST_LEN, DEPTH-Occ).
  - Computed in ADDR_W+1 bits with no wrap.
- Abort: ChReset on the granted channel during BURST -> IDLE. Global Reset from any state -> IDLE.

## Timing
- Reset values: IF_Req 0, IF_RdWr 1, IF_Cfg IDLE_CODE, Grant 0, Occ 0, Err 0, round-robin pointers at index NUM_CH-1.
- Occ updates on the clock edge after a strobe; request evaluation uses the registered Occ.
- Grant latency: IF_Req and the other outputs rise 1 cycle after a request is seen in IDLE.
- After the final beat, IF_Req is 0 on the next cycle. IDLE lasts at least one cycle between bursts, so re-arbitration takes 2 cycles from the last beat.
- IF_Cfg, IF_RdWr and Grant are stable for the whole burst. Requests that change mid-burst do not preempt the burst.
- An abort drops IF_Req on the cycle after ChReset.

## Structure
- Shared include ifarb_pkg.vh holds: FSM state encodings (IDLE, BURST), the CFG/IDLE code defaults, and an occupancy width macro of ADDR_W+1.
- Sub-module gbf_occ_cnt, instantiated NUM_CH times: occupancy counter with saturation, Err, and ChReset.
- Arbiter, FSM and beat counter live at the top level.

## Test plan
- Refill trigger: ch0 Thresh=8, Occ=0 -> IF_Req one cycle after reset release, IF_Cfg=8, IF_RdWr=1, Grant=000001, exactly 8 beats, then IF_Req=0.
- Drain priority: ch4 Occ=24 with Thresh=24 and ch0 requesting simultaneously -> ch4 granted first (IF_Cfg=10, IF_RdWr=0); ch0 granted 2 cycles after ch4's last beat.
- Flush truncation: ch5 Occ=3, Thresh=24, Flush=1 -> burst of 3 beats, IF_Cfg=11.
- Round-robin: RR_En=1 with ch0–ch3 all requesting continuously -> grant order 0,1,2,3,0; with RR_En=0 -> 0,0,0.
- Boundaries: EnWr held 33 cycles on ch1 -> Occ saturates at 32 and Err[1]=1. Simultaneous EnWr and EnRd -> Occ unchanged.
- Abort and reset: ChReset on the granted channel after 2 of 8 beats -> IF_Req=0 next cycle; Reset mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/ifarb_multi_pkg.sv
// ifarb_multi_pkg: shared types and defaults for the global-buffer interface arbiter.
//   state_e         - burst FSM state encoding (StIdle, StBurst)
//   CFG_CODE_DEF    - default IF_Cfg code for configuration fetch bursts
//   IDLE_CODE_DEF   - default IF_Cfg code while nothing is granted
//   occ_w()         - occupancy width for a given address width (0..DEPTH needs ADDR_W+1 bits)
package ifarb_multi_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    localparam logic [3:0] CFG_CODE_DEF  = 4'd0;
    localparam logic [3:0] IDLE_CODE_DEF = 4'd15;

    function automatic int unsigned occ_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/gbf_occ_cnt.sv
// gbf_occ_cnt: occupancy counter for one global buffer channel.
//   clk      in   clock
//   Reset    in   synchronous active-high global reset
//   ChReset  in   synchronous clear of this channel's occupancy and error flag
//   EnWr     in   buffer write strobe (+1)
//   EnRd     in   buffer read strobe (-1)
//   Occ      out  current occupancy, 0..2**ADDR_W
//   Err      out  sticky flag: write while full or read while empty
module gbf_occ_cnt
    import ifarb_multi_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          ChReset,
    input  logic                          EnWr,
    input  logic                          EnRd,
    output logic [occ_w(ADDR_W)-1:0]      Occ,
    output logic                          Err
);

    localparam int unsigned OCC_W = occ_w(ADDR_W);
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(2 ** ADDR_W);

    logic [OCC_W-1:0] r_occ, w_occ_d;
    logic             r_err, w_err_d;

    // Simultaneous write and read cancel; out-of-range strobes are dropped and flagged.
    always_comb begin
        w_occ_d = r_occ;
        w_err_d = r_err;
        if (EnWr && !EnRd) begin
            if (r_occ == DEPTH_V) w_err_d = 1'b1;
            else                  w_occ_d = r_occ + OCC_W'(1);
        end else if (EnRd && !EnWr) begin
            if (r_occ == '0) w_err_d = 1'b1;
            else             w_occ_d = r_occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset || ChReset) begin
            r_occ <= '0;
            r_err <= 1'b0;
        end else begin
            r_occ <= w_occ_d;
            r_err <= w_err_d;
        end
    end

    assign Occ = r_occ;
    assign Err = r_err;

endmodule

// File: rtl/ifarb_multi.sv
// ifarb_multi: arbitrates NUM_CH global buffers plus a configuration fetch onto one
// off-chip interface port, granting counted bursts truncated to the channel occupancy.
//   clk, Reset           clock, synchronous active-high reset
//   ChReset/EnWr/EnRd    per-channel clear and occupancy strobes
//   Thresh               per-channel watermark, packed, channel 0 in LSBs
//   Flush                per-channel forced drain of any non-zero occupancy (drain channels)
//   CFG_Req, RR_En       config fetch request; round-robin enable within a class
//   IF_Val, IF_Rdy       interface handshake; a beat is IF_Val && IF_Rdy
//   IF_Req, IF_RdWr      level burst request; 1 = read (refill/CFG), 0 = write (drain)
//   IF_Cfg, Grant        code and one-hot channel of the granted source
//   Occ, Err             per-channel occupancy and sticky error
module ifarb_multi
    import ifarb_multi_pkg::*;
#(
    parameter int unsigned               NUM_CH    = 6,
    parameter int unsigned               ADDR_W    = 5,
    parameter int unsigned               CFG_W     = 4,
    parameter int unsigned               BURST_LEN = 8,
    parameter logic [NUM_CH-1:0]         CH_DIR    = 6'b110000,
    parameter logic [NUM_CH*CFG_W-1:0]   CH_CFG    = {4'd11, 4'd10, 4'd2, 4'd4, 4'd6, 4'd8},
    parameter logic [CFG_W-1:0]          CFG_CODE  = CFG_CODE_DEF,
    parameter logic [CFG_W-1:0]          IDLE_CODE = IDLE_CODE_DEF
) (
    input  logic                              clk,
    input  logic                              Reset,
    input  logic [NUM_CH-1:0]                 ChReset,
    input  logic [NUM_CH-1:0]                 EnWr,
    input  logic [NUM_CH-1:0]                 EnRd,
    input  logic [NUM_CH*occ_w(ADDR_W)-1:0]   Thresh,
    input  logic [NUM_CH-1:0]                 Flush,
    input  logic                              CFG_Req,
    input  logic                              RR_En,
    input  logic                              IF_Val,
    input  logic                              IF_Rdy,
    output logic                              IF_Req,
    output logic                              IF_RdWr,
    output logic [CFG_W-1:0]                  IF_Cfg,
    output logic [NUM_CH-1:0]                 Grant,
    output logic [NUM_CH*occ_w(ADDR_W)-1:0]   Occ,
    output logic [NUM_CH-1:0]                 Err
);

    localparam int unsigned OCC_W = occ_w(ADDR_W);
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(2 ** ADDR_W);
    localparam logic [OCC_W-1:0] BURST_V = OCC_W'(BURST_LEN);

    logic [OCC_W-1:0]  w_occ  [NUM_CH];
    logic [OCC_W-1:0]  w_free [NUM_CH];
    logic [NUM_CH-1:0] w_drn_req, w_ref_req;
    logic [IDX_W:0]    w_pick_drn, w_pick_ref;

    state_e            r_state, w_state_d;
    logic              r_rdwr, w_rdwr_d;
    logic [CFG_W-1:0]  r_cfg, w_cfg_d;
    logic [NUM_CH-1:0] r_grant, w_grant_d;
    logic [OCC_W-1:0]  r_beats, w_beats_d;
    logic [IDX_W-1:0]  r_ptr_drn, w_ptr_drn_d;
    logic [IDX_W-1:0]  r_ptr_ref, w_ptr_ref_d;
    logic [IDX_W-1:0]  w_idx;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gbf_occ_cnt #(
            .ADDR_W (ADDR_W)
        ) u_occ (
            .clk     (clk),
            .Reset   (Reset),
            .ChReset (ChReset[g]),
            .EnWr    (EnWr[g]),
            .EnRd    (EnRd[g]),
            .Occ     (w_occ[g]),
            .Err     (Err[g])
        );
        assign Occ[g*OCC_W +: OCC_W] = w_occ[g];
    end

    // A drain with zero occupancy would latch a zero-beat burst, so it never requests.
    always_comb begin
        w_drn_req = '0;
        w_ref_req = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_free[i] = DEPTH_V - w_occ[i];
            if (CH_DIR[i]) begin
                w_drn_req[i] = (w_occ[i] != '0) &&
                               ((w_occ[i] >= Thresh[i*OCC_W +: OCC_W]) || Flush[i]);
            end else begin
                w_ref_req[i] = (w_free[i] != '0) && (w_free[i] >= Thresh[i*OCC_W +: OCC_W]);
            end
        end
    end

    // Returns {hit, index}. Scans backwards so the highest-priority candidate is written last.
    function automatic logic [IDX_W:0] pick(input logic [NUM_CH-1:0] req,
                                            input logic [IDX_W-1:0]  ptr,
                                            input logic              rr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            j = rr ? int'(ptr) + 1 + k : k;
            if (j >= int'(NUM_CH)) j = j - int'(NUM_CH);
            if (req[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    assign w_pick_drn = pick(w_drn_req, r_ptr_drn, RR_En);
    assign w_pick_ref = pick(w_ref_req, r_ptr_ref, RR_En);

    always_comb begin
        w_state_d   = r_state;
        w_rdwr_d    = r_rdwr;
        w_cfg_d     = r_cfg;
        w_grant_d   = r_grant;
        w_beats_d   = r_beats;
        w_ptr_drn_d = r_ptr_drn;
        w_ptr_ref_d = r_ptr_ref;
        w_idx       = '0;
        case (r_state)
            StIdle: begin
                if (CFG_Req) begin
                    w_state_d = StBurst;
                    w_rdwr_d  = 1'b1;
                    w_cfg_d   = CFG_CODE;
                    w_grant_d = '0;
                    w_beats_d = OCC_W'(1);
                end else if (w_pick_drn[IDX_W]) begin
                    w_idx       = w_pick_drn[IDX_W-1:0];
                    w_state_d   = StBurst;
                    w_rdwr_d    = 1'b0;
                    w_cfg_d     = CH_CFG[w_idx*CFG_W +: CFG_W];
                    w_grant_d   = NUM_CH'(1) << w_idx;
                    w_beats_d   = (w_occ[w_idx] < BURST_V) ? w_occ[w_idx] : BURST_V;
                    w_ptr_drn_d = w_idx;
                end else if (w_pick_ref[IDX_W]) begin
                    w_idx       = w_pick_ref[IDX_W-1:0];
                    w_state_d   = StBurst;
                    w_rdwr_d    = 1'b1;
                    w_cfg_d     = CH_CFG[w_idx*CFG_W +: CFG_W];
                    w_grant_d   = NUM_CH'(1) << w_idx;
                    w_beats_d   = (w_free[w_idx] < BURST_V) ? w_free[w_idx] : BURST_V;
                    w_ptr_ref_d = w_idx;
                end
            end
            StBurst: begin
                // Clearing the granted buffer invalidates the burst in flight.
                if ((|(ChReset & r_grant)) || (IF_Val && IF_Rdy && r_beats == OCC_W'(1))) begin
                    w_state_d = StIdle;
                    w_rdwr_d  = 1'b1;
                    w_cfg_d   = IDLE_CODE;
                    w_grant_d = '0;
                    w_beats_d = '0;
                end else if (IF_Val && IF_Rdy) begin
                    w_beats_d = r_beats - OCC_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= StIdle;
            r_rdwr    <= 1'b1;
            r_cfg     <= IDLE_CODE;
            r_grant   <= '0;
            r_beats   <= '0;
            r_ptr_drn <= IDX_W'(NUM_CH - 1);
            r_ptr_ref <= IDX_W'(NUM_CH - 1);
        end else begin
            r_state   <= w_state_d;
            r_rdwr    <= w_rdwr_d;
            r_cfg     <= w_cfg_d;
            r_grant   <= w_grant_d;
            r_beats   <= w_beats_d;
            r_ptr_drn <= w_ptr_drn_d;
            r_ptr_ref <= w_ptr_ref_d;
        end
    end

    assign IF_Req  = (r_state == StBurst);
    assign IF_RdWr = r_rdwr;
    assign IF_Cfg  = r_cfg;
    assign Grant   = r_grant;

endmodule

// File: tb/tb_ifarb_multi.sv
// tb_ifarb_multi: directed self-checking bench for ifarb_multi with default parameters.
module tb_ifarb_multi;

    logic        clk = 1'b0;
    logic        Reset;
    logic [5:0]  ChReset, EnWr, EnRd, Flush;
    logic        CFG_Req, RR_En, IF_Val, IF_Rdy;
    logic [5:0]  thr [6];
    logic [35:0] Thresh;
    logic        IF_Req, IF_RdWr;
    logic [3:0]  IF_Cfg;
    logic [5:0]  Grant, Err;
    logic [35:0] Occ;

    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    always_comb begin
        Thresh = '0;
        for (int i = 0; i < 6; i++) Thresh[i*6 +: 6] = thr[i];
    end

    ifarb_multi dut (
        .clk     (clk),
        .Reset   (Reset),
        .ChReset (ChReset),
        .EnWr    (EnWr),
        .EnRd    (EnRd),
        .Thresh  (Thresh),
        .Flush   (Flush),
        .CFG_Req (CFG_Req),
        .RR_En   (RR_En),
        .IF_Val  (IF_Val),
        .IF_Rdy  (IF_Rdy),
        .IF_Req  (IF_Req),
        .IF_RdWr (IF_RdWr),
        .IF_Cfg  (IF_Cfg),
        .Grant   (Grant),
        .Occ     (Occ),
        .Err     (Err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] occ_of(input int i);
        return Occ[i*6 +: 6];
    endfunction

    // Holds the handshake high and counts beats until IF_Req drops (bounded).
    task automatic run_burst(output int beats);
        beats  = 0;
        IF_Val = 1'b1;
        IF_Rdy = 1'b1;
        while (IF_Req && beats < 40) begin
            tick();
            beats++;
        end
        IF_Val = 1'b0;
        IF_Rdy = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int t;
        t = 0;
        while (!IF_Req && t < 10) begin
            tick();
            t++;
        end
        check({tag, "_req"}, IF_Req, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};
        Reset = 1'b1; ChReset = '0; EnWr = '0; EnRd = '0; Flush = '0;
        CFG_Req = 1'b0; RR_En = 1'b0; IF_Val = 1'b0; IF_Rdy = 1'b0;
        for (int i = 0; i < 6; i++) thr[i] = 6'd63;
        tick(); tick();
        check("rst_req", IF_Req, 0);
        check("rst_rdwr", IF_RdWr, 1);
        check("rst_cfg", IF_Cfg, 15);
        check("rst_grant", Grant, 0);
        check("rst_occ", Occ, 0);
        check("rst_err", Err, 0);

        // Refill trigger on ch0
        thr[0] = 6'd8;
        tick();
        check("t1_held", IF_Req, 0);
        Reset = 1'b0;
        tick();
        check("t1_req", IF_Req, 1);
        check("t1_cfg", IF_Cfg, 8);
        check("t1_rdwr", IF_RdWr, 1);
        check("t1_grant", Grant, 6'b000001);
        thr[0] = 6'd63;
        run_burst(n);
        check("t1_beats", n, 8);
        tick();
        check("t1_idle", IF_Req, 0);

        // Drain beats refill
        EnWr = 6'b010000;
        repeat (24) tick();
        EnWr = '0;
        check("t2_occ4", occ_of(4), 24);
        thr[4] = 6'd24;
        thr[0] = 6'd8;
        tick();
        check("t2_cfg", IF_Cfg, 10);
        check("t2_rdwr", IF_RdWr, 0);
        check("t2_grant", Grant, 6'b010000);
        thr[4] = 6'd63;
        run_burst(n);
        check("t2_beats", n, 8);
        check("t2_gap", IF_Req, 0);
        tick();
        check("t2_ch0_grant", Grant, 6'b000001);
        check("t2_ch0_cfg", IF_Cfg, 8);
        thr[0] = 6'd63;
        run_burst(n);
        check("t2_ch0_beats", n, 8);

        // Flush truncation on ch5
        EnWr = 6'b100000;
        repeat (3) tick();
        EnWr = '0;
        thr[5] = 6'd24;
        Flush  = 6'b100000;
        tick();
        check("t3_cfg", IF_Cfg, 11);
        check("t3_grant", Grant, 6'b100000);
        check("t3_rdwr", IF_RdWr, 0);
        Flush = '0;
        run_burst(n);
        check("t3_beats", n, 3);

        // CFG_Req outranks a refill request
        CFG_Req = 1'b1;
        thr[0]  = 6'd8;
        tick();
        check("cfg_req", IF_Req, 1);
        check("cfg_cfg", IF_Cfg, 0);
        check("cfg_rdwr", IF_RdWr, 1);
        check("cfg_grant", Grant, 0);
        CFG_Req = 1'b0;
        run_burst(n);
        check("cfg_beats", n, 1);
        tick();
        check("cfg_next", Grant, 6'b000001);
        thr[0] = 6'd63;
        run_burst(n);

        // Round-robin and fixed priority among ch0..ch3
        Reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) thr[i] = 6'd8;
        RR_En = 1'b1;
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_req("rr");
            check($sformatf("rr_grant%0d", k), Grant, 64'(6'd1 << exp_rr[k]));
            run_burst(n);
        end
        RR_En = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_req("fix");
            check($sformatf("fix_grant%0d", k), Grant, 6'b000001);
            run_burst(n);
        end
        for (int i = 0; i < 4; i++) thr[i] = 6'd63;

        // Occupancy boundaries
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        EnWr = 6'b000010;
        repeat (32) tick();
        check("b_occ1_full", occ_of(1), 32);
        check("b_err1_pre", Err[1], 0);
        tick();
        EnWr = '0;
        check("b_occ1_sat", occ_of(1), 32);
        check("b_err1", Err[1], 1);
        EnWr = 6'b001000;
        repeat (5) tick();
        EnWr = 6'b001000;
        EnRd = 6'b001000;
        repeat (3) tick();
        EnWr = '0;
        EnRd = '0;
        check("b_occ3_both", occ_of(3), 5);
        check("b_err3", Err[3], 0);
        EnRd = 6'b000100;
        tick();
        EnRd = '0;
        check("b_occ2_under", occ_of(2), 0);
        check("b_err2", Err[2], 1);
        ChReset = 6'b000010;
        tick();
        ChReset = '0;
        check("b_chrst_occ1", occ_of(1), 0);
        check("b_chrst_err1", Err[1], 0);
        check("b_keep_occ3", occ_of(3), 5);

        // Abort by ChReset on the granted channel
        thr[0] = 6'd8;
        tick();
        check("ab_grant", Grant, 6'b000001);
        thr[0] = 6'd63;
        IF_Val = 1'b1;
        IF_Rdy = 1'b1;
        tick(); tick();
        IF_Val = 1'b0;
        IF_Rdy = 1'b0;
        check("ab_mid", IF_Req, 1);
        ChReset = 6'b000001;
        tick();
        ChReset = '0;
        check("ab_req", IF_Req, 0);
        check("ab_grant0", Grant, 0);
        check("ab_cfg", IF_Cfg, 15);

        // Global reset mid-burst
        thr[0] = 6'd8;
        tick();
        check("rm_req", IF_Req, 1);
        thr[0] = 6'd63;
        IF_Val = 1'b1;
        IF_Rdy = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        Reset  = 1'b0;
        IF_Val = 1'b0;
        IF_Rdy = 1'b0;
        check("rm_req0", IF_Req, 0);
        check("rm_rdwr", IF_RdWr, 1);
        check("rm_cfg", IF_Cfg, 15);
        check("rm_grant", Grant, 0);
        check("rm_occ", Occ, 0);
        check("rm_err", Err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
